serial_alu_ctrl: RTL and testbench
==================================

Name: serial_alu_ctrl

Overview:
Bit-serial add/subtract sequencer for the SAP ALU path. It owns a single 1-bit full_adder cell and steps it across a WIDTH-bit operand pair, one bit per clock, LSB first. It holds the carry between bits and registers the result and flags. It sits between the control sequencer (start/done handshake) and the A/B registers and bus, replacing a WIDTH-wide ripple adder.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  request an operation; sampled only in IDLE.
- sub  in  1  0 = A+B, 1 = A-B; sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- busy  out  1  high while state is not IDLE.
- done  out  1  one-cycle pulse when result and flags become valid.
- result  out  WIDTH  registered sum/difference; holds until the next completion.
- carry  out  1  carry out of MSB; for subtract, 1 = no borrow.
- zero  out  1  1 when result is 0.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. Assertion at any time (including mid-operation) forces state IDLE. It also clears busy, done, result, carry, zero, the bit counter, the internal shift registers and the carry flop to 0. No operation resumes after reset.
- State machine: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - On start=1 at edge E0: latch a into a_sh, latch b^{WIDTH{sub}} into b_sh, set carry flop cq = sub, set cnt = 0, go to RUN.
  - start=0: stay in IDLE.
- RUN, at each edge:
  - full_adder inputs: a_sh[0], b_sh[0], cq.
  - Shift s into the MSB of sum_sh (right shift).
  - Shift a_sh and b_sh right by one.
  - cq <= cout.
  - cnt <= cnt+1.
  - When cnt == WIDTH-1 at that edge, go to DONE, and on the same edge load:
    - result <= {s, sum_sh[WIDTH-1:1]}
    - carry <= cout
    - zero <= (that value == 0)
- DONE: done=1 for exactly one cycle, then IDLE on the next edge.
- Latency: RUN occupies edges E1..EW. done is high between EW and E(W+1). busy is high from E0 to E(W+1).
- start handling:
  - start while busy (RUN or DONE) is ignored, with no queueing; the requester must re-assert start after done.
  - Operands and sub are not re-sampled during RUN, so changing a, b or sub mid-operation has no effect.
- Output stability: result, carry and zero change only on the RUN->DONE edge (or on reset). During RUN they still show the previous operation's values.
- Arithmetic: modulo 2^WIDTH. Subtract is A + ~B + 1, and carry=0 signals a borrow.
- cnt width is $clog2(WIDTH). Wrap-around is not possible because cnt is compared with WIDTH-1.

Optional Feature:
Macro SERIAL_ALU_OVF_EN.
- Defined:
  - Adds output ovf (1 bit, reset 0).
  - On the last RUN edge, ovf <= cq XOR cout, i.e. carry into MSB XOR carry out of MSB (two's-complement overflow).
  - ovf is registered with result and holds likewise.
- Undefined: no ovf port and no extra logic; all other behaviour is identical.

Decomposition:
- Package sap_alu_pkg:
  - State encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Op-select constants OP_ADD=1'b0, OP_SUB=1'b1.
- Sub-module: exactly one instance of the existing common full_adder (a, b, cin, s, cout). No other arithmetic on the bit path.

Test Plan (WIDTH=8):
- add 0x05+0x03, sub=0 -> done pulses W=8 edges after start: result=0x08, carry=0, zero=0, busy low one cycle after done.
- add 0xFF+0x01 -> result=0x00, carry=1, zero=1; with SERIAL_ALU_OVF_EN also check 0x7F+0x01 -> result=0x80, ovf=1, carry=0.
- sub 0x05-0x07 -> result=0xFE, carry=0 (borrow), zero=0; sub 0x10-0x10 -> result=0x00, carry=1, zero=1.
- start re-pulsed at E3 with new a/b during RUN -> ignored; first result only, with exactly one done pulse.
- rst_n low at E4 mid-RUN -> busy, done, result, carry, zero are 0 immediately (async). After release, start 0x02+0x02 -> result=0x04 with normal latency.
- back-to-back: start held high continuously -> a new operation begins each time IDLE is reached, with a period of W+2 cycles and one done per operation.

Source files
------------

// File: rtl/sap_alu_pkg.sv
// Shared encodings for the SAP ALU path: FSM state codes and op-select values.
// Imported by serial_alu_ctrl.
package sap_alu_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Common 1-bit full adder cell.
// Ports: a, b, cin in; s (sum), cout (carry out) out.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial add/subtract sequencer: one full_adder stepped LSB-first over WIDTH bits.
// Ports: clk, rst_n (async low), start/sub/a/b in; busy, done, result, carry, zero
// out; ovf out only when SERIAL_ALU_OVF_EN is defined.
module serial_alu_ctrl
    import sap_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
`ifdef SERIAL_ALU_OVF_EN
    output logic             ovf,
`endif
    output logic             zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           st;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Upper WIDTH-1 bits of the sum shifter; the bit that would fall
    // off the bottom is never needed, so it is not stored.
    logic [WIDTH-2:0] sum_hi;
    logic             cq;
    logic [CW-1:0]    cnt;
    logic             s;
    logic             cout;
    logic [WIDTH-1:0] nxt;
    logic             last;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (cq),
        .s    (s),
        .cout (cout)
    );

    assign nxt  = {s, sum_hi};
    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_hi <= '0;
            cq     <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            unique case (st)
                IDLE: begin
                    if (start) begin
                        a_sh <= a;
                        // Subtract is A + ~B + 1: invert B, seed carry with 1.
                        b_sh <= b ^ {WIDTH{sub == OP_SUB}};
                        cq   <= sub;
                        cnt  <= '0;
                        busy <= 1'b1;
                        st   <= RUN;
                    end
                end
                RUN: begin
                    sum_hi <= nxt[WIDTH-1:1];
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    cq     <= cout;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        result <= nxt;
                        carry  <= cout;
                        zero   <= (nxt == '0);
`ifdef SERIAL_ALU_OVF_EN
                        // Carry into MSB vs carry out of MSB.
                        ovf    <= cq ^ cout;
`endif
                        done   <= 1'b1;
                        st     <= DONE;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    st   <= IDLE;
                end
                default: begin
                    st <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Scoreboard bench for serial_alu_ctrl (WIDTH=8): directed and random ops,
// ignored restarts, async reset mid-run and back-to-back starts.
module tb_serial_alu_ctrl;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         z;
        logic         o;
        int           t;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry;
    logic         zero;
`ifdef SERIAL_ALU_OVF_EN
    logic         ovf;
`endif

    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    exp_t q[$];

    serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .carry  (carry),
`ifdef SERIAL_ALU_OVF_EN
        .ovf    (ovf),
`endif
        .zero   (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic modulo 2^W, signed range for overflow.
    function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y, logic s, int t);
        exp_t e;
        int   full;
        int   sx;
        int   sy;
        int   sr;
        full = s ? (int'(x) + (1 << W) - int'(y)) : (int'(x) + int'(y));
        sx   = x[W-1] ? int'(x) - (1 << W) : int'(x);
        sy   = y[W-1] ? int'(y) - (1 << W) : int'(y);
        sr   = s ? sx - sy : sx + sy;
        e.r  = W'(full % (1 << W));
        e.c  = (full >= (1 << W));
        e.z  = (full % (1 << W)) == 0;
        e.o  = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
        e.t  = t;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'(0));
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", 32'(result), 32'(e.r));
                chk("carry", 32'(carry), 32'(e.c));
                chk("zero", 32'(zero), 32'(e.z));
                chk("done_cycle", 32'(cyc), 32'(e.t));
`ifdef SERIAL_ALU_OVF_EN
                chk("ovf", 32'(ovf), 32'(e.o));
`endif
            end
        end
    end

    // Drive one start pulse; returns at the negedge after E0.
    task automatic issue(logic [W-1:0] x, logic [W-1:0] y, logic s, bit push, output int e0);
        @(negedge clk);
        start = 1'b1;
        a = x;
        b = y;
        sub = s;
        e0 = cyc + 1;
        if (push) q.push_back(model(x, y, s, e0 + W));
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'(1));
    endtask

    // Wait for busy to drop, scrambling operands; they must not be resampled.
    task automatic wait_idle(int exp_idle);
        int n;
        n = 0;
        while (busy && n < 4 * W) begin
            a = W'($urandom);
            b = W'($urandom);
            sub = 1'($urandom);
            @(negedge clk);
            n++;
        end
        chk("busy_low", 32'(busy), 32'(0));
        chk("idle_cycle", 32'(cyc), 32'(exp_idle));
    endtask

    task automatic op(logic [W-1:0] x, logic [W-1:0] y, logic s);
        int e0;
        issue(x, y, s, 1'b1, e0);
        wait_idle(e0 + W + 1);
    endtask

    initial begin
        int e0;
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int e0;
        int gap;

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_result", 32'(result), 32'(0));
        chk("rst_carry", 32'(carry), 32'(0));
        chk("rst_zero", 32'(zero), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        op(8'h05, 8'h03, 1'b0);
        op(8'hFF, 8'h01, 1'b0);
        op(8'h7F, 8'h01, 1'b0);
        op(8'h05, 8'h07, 1'b1);
        op(8'h10, 8'h10, 1'b1);
        op(8'h80, 8'h01, 1'b1);

        // Restart request during RUN at E3 is dropped.
        issue(8'h21, 8'h12, 1'b0, 1'b1, e0);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        a = 8'hAA;
        b = 8'h55;
        @(negedge clk);
        start = 1'b0;
        wait_idle(e0 + W + 1);
        repeat (3) @(negedge clk);

        // Async reset mid-RUN, then a normal op.
        issue(8'h33, 8'h44, 1'b0, 1'b0, e0);
        while (cyc < e0 + 4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_done", 32'(done), 32'(0));
        chk("arst_result", 32'(result), 32'(0));
        chk("arst_carry", 32'(carry), 32'(0));
        chk("arst_zero", 32'(zero), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 4) @(negedge clk);
        chk("no_resume", 32'(busy), 32'(0));
        op(8'h02, 8'h02, 1'b0);

        // Start held high: one op every W+2 cycles.
        @(negedge clk);
        start = 1'b1;
        a = 8'hC8;
        b = 8'h64;
        sub = 1'b0;
        e0 = cyc + 1;
        for (int k = 0; k < 3; k++) q.push_back(model(8'hC8, 8'h64, 1'b0, e0 + W + k * (W + 2)));
        while (cyc < e0 + 3 * W + 5) @(negedge clk);
        start = 1'b0;
        wait_idle(e0 + 2 * (W + 2) + W + 1);

        for (int i = 0; i < 40; i++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            op(W'($urandom), W'($urandom), 1'($urandom));
        end

        repeat (4) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
